// File: rtl/keypad_pkg.sv
// keypad_pkg: shared column-drive encoding, empty-snapshot constant and
// key-position-to-hex-code mapping for the keypad scanner.
package keypad_pkg;

  typedef enum logic [3:0] {
    COL_0 = 4'b1110,
    COL_1 = 4'b1101,
    COL_2 = 4'b1011,
    COL_3 = 4'b0111
  } col_drive_e;

  localparam logic [15:0] KEY_NONE = 16'h0;

  // Layout, col 0..3 left to right:
  //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a new 16-bit key snapshot once DEBOUNCE_FRAMES
// consecutive identical frames have been seen.
//   clk, rst_n          clock, synchronous active-low reset
//   frame_valid         one-cycle strobe, frame holds a complete scan
//   frame[15:0]         bit 4*c+r set = key at column c, row r pressed
//   debounced[15:0]     accepted snapshot
//   debounced_changed   one-cycle strobe when debounced takes a new value
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [15:0] frame,
  output logic [15:0] debounced,
  output logic        debounced_changed
);

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_FRAMES);

  logic [15:0] prev_frame;
  logic [3:0]  stable_cnt;
  logic [3:0]  stable_next;

  always_comb begin
    stable_next = 4'd1;
    if (frame == prev_frame) begin
      stable_next = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_frame        <= KEY_NONE;
      stable_cnt        <= '0;
      debounced         <= KEY_NONE;
      debounced_changed <= 1'b0;
    end else begin
      debounced_changed <= 1'b0;
      if (frame_valid) begin
        prev_frame <= frame;
        stable_cnt <= stable_next;
        if (stable_next == STABLE_MAX && frame != debounced) begin
          debounced         <= frame;
          debounced_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame debounce and a
// valid/ready key-code output.
//   clk, rst_n     clock, synchronous active-low reset
//   col[3:0]       column drive, active-low, one bit low per SCAN_TICKS slot
//   row[3:0]       row sense, active-low, asynchronous
//   key_code[3:0]  hex code of pending press
//   key_valid      key_code holds an unconsumed press
//   key_ready      consumer accept (transfer on key_valid & key_ready)
//   key_down       debounced snapshot has at least one key pressed
//   key_overflow   sticky, a press was dropped while key_valid was pending
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of a held key).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_DELAY    = 125,
  parameter int unsigned REPEAT_RATE     = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       key_overflow
);

  localparam int unsigned     SLOT_W    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_TICKS - 1);

  logic [3:0]        row_meta;
  logic [3:0]        row_sync;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  col_drive_e        col_q;
  logic [11:0]       frame_acc;
  logic              slot_end;
  logic              frame_end;
  logic [15:0]       frame_now;
  logic [15:0]       debounced;
  logic [15:0]       deb_last;
  logic              deb_changed;
  logic [3:0]        ev_idx;
  logic [3:0]        ev_code;
  logic              press_ev;
  logic              ev;

  assign col       = col_q;
  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);
  // Column 3 is sampled straight into the completed frame, not into frame_acc.
  assign frame_now = {~row_sync, frame_acc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      col_idx   <= '0;
      col_q     <= COL_0;
      frame_acc <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
      col_q    <= col_drive_e'({col_q[2:0], col_q[3]});
      case (col_idx)
        2'd0:    frame_acc[3:0]  <= ~row_sync;
        2'd1:    frame_acc[7:4]  <= ~row_sync;
        2'd2:    frame_acc[11:8] <= ~row_sync;
        default: ;
      endcase
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_valid      (frame_end),
    .frame            (frame_now),
    .debounced        (debounced),
    .debounced_changed(deb_changed)
  );

  always_comb begin
    ev_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (debounced[i]) ev_idx = 4'(i);
    end
  end

  assign ev_code  = map_key(ev_idx[1:0], ev_idx[3:2]);
  assign press_ev = deb_changed && (deb_last == KEY_NONE) && $onehot(debounced);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_last <= KEY_NONE;
    end else if (deb_changed) begin
      deb_last <= debounced;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic        tick_d;
  logic        rep_armed;
  logic        rep_phase;
  logic [15:0] rep_cnt;
  logic [15:0] rep_limit;
  logic        rep_ev;

  // tick_d lines up with deb_changed, both one cycle after the frame end.
  assign rep_limit = rep_phase ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
  assign rep_ev    = tick_d && rep_armed && !deb_changed && (rep_cnt + 16'd1 == rep_limit);
  assign ev        = press_ev || rep_ev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_d    <= 1'b0;
      rep_armed <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      tick_d <= frame_end;
      if (deb_changed) begin
        rep_armed <= press_ev;
        rep_phase <= 1'b0;
        rep_cnt   <= '0;
      end else if (tick_d && rep_armed) begin
        if (rep_ev) begin
          rep_phase <= 1'b1;
          rep_cnt   <= '0;
        end else begin
          rep_cnt <= rep_cnt + 16'd1;
        end
      end
    end
  end
`else
  logic repeat_cfg_unused;
  assign repeat_cfg_unused = |{REPEAT_DELAY, REPEAT_RATE};
  assign ev                = press_ev;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_code     <= '0;
      key_valid    <= 1'b0;
      key_down     <= 1'b0;
      key_overflow <= 1'b0;
    end else begin
      key_down <= |debounced;
      if (ev) begin
        if (!key_valid || key_ready) begin
          key_code  <= ev_code;
          key_valid <= 1'b1;
        end else begin
          key_overflow <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;
  logic       key_overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] pressed;
  logic        row_force;
  logic [3:0]  row_force_val;
  logic [3:0]  exp_q[$];

  keypad_scanner #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_FRAMES(2),
    .REPEAT_DELAY   (3),
    .REPEAT_RATE    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col         (col),
    .row         (row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_down    (key_down),
    .key_overflow(key_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Keypad matrix: a pressed key at (c,r) pulls row r low while column c is driven low.
  always_comb begin
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (col[c] == 1'b0) r = r & ~pressed[4*c +: 4];
    end
    row = row_force ? row_force_val : r;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n         = 1'b0;
    row_force     = 1'b1;
    row_force_val = 4'b0000;
    pressed       = '0;
    key_ready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    row_force = 1'b0;
  endtask

  task automatic wait_frame_start();
    logic [3:0] p;
    bit ok;
    ok = 1'b0;
    p  = col;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (p == 4'b0111 && col == 4'b1110) ok = 1'b1;
      p = col;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_start: no column wrap seen within 40 clk, col=%b required wrap 0111->1110", col);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = key_valid;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = key_valid;
    end
  endtask

  task automatic wait_down(input logic level, input int budget, output bit ok);
    ok = (key_down == level);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (key_down == level);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    row_force     = 1'b1;
    row_force_val = 4'b0000;
    pressed       = '0;
    key_ready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++;
    if (key_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", key_overflow); end
    checks++;
    if (key_down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b expected 0", key_down); end
    checks++;
    if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", key_code); end
    rst_n     = 1'b1;
    row_force = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] prev;
    int run;
    int changes;
    int bad_shape;
    apply_reset();
    prev      = col;
    run       = 1;
    changes   = 0;
    bad_shape = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(col == 4'b1110 || col == 4'b1101 || col == 4'b1011 || col == 4'b0111)) bad_shape++;
      if (col == prev) begin
        run++;
      end else begin
        changes++;
        checks++;
        if (col !== {prev[2:0], prev[3]}) begin
          errors++;
          $display("FAIL rotate_order: got %b after %b expected %b", col, prev, {prev[2:0], prev[3]});
        end
        checks++;
        if (run != 4) begin
          errors++;
          $display("FAIL rotate_slot: column %b held %0d clk expected 4", prev, run);
        end
        run = 1;
      end
      prev = col;
    end
    checks++;
    if (bad_shape != 0) begin
      errors++;
      $display("FAIL col_onehot: %0d cycles with col not exactly one low bit, expected 0", bad_shape);
    end
    checks++;
    if (changes != 10) begin
      errors++;
      $display("FAIL rotate_count: got %0d column changes in 40 clk expected 10", changes);
    end
  endtask

  task automatic test_single_press();
    bit ok;
    int quiet_bad;
    logic [3:0] exp;
    apply_reset();
    wait_frame_start();
    exp_q.push_back(4'h5);
    pressed = 16'h0020;
    wait_valid(35, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: key_valid=%b after 35 clk expected 1", key_valid);
    end else begin
      exp = exp_q.pop_front();
      if (key_code !== exp) begin
        errors++;
        $display("FAIL single_code: got %h expected %h", key_code, exp);
      end
    end
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("FAIL single_down: got %b expected 1", key_down); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL single_consume: key_valid=%b expected 0", key_valid); end
    quiet_bad = 0;
    repeat (96) begin
      @(negedge clk);
      if (key_valid !== 1'b0) quiet_bad++;
    end
    checks++;
    if (quiet_bad != 0) begin
      errors++;
      $display("FAIL single_hold: key_valid high %0d clk while key held, expected 0", quiet_bad);
    end
    pressed = '0;
    wait_down(1'b0, 64, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_release: key_down=%b expected 0", key_down); end
  endtask

  task automatic test_bounce();
    bit ok;
    int noise_bad;
    logic [3:0] exp;
    apply_reset();
    wait_frame_start();
    noise_bad = 0;
    for (int k = 0; k < 6; k++) begin
      pressed = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (16) begin
        @(negedge clk);
        if (key_valid !== 1'b0 || key_down !== 1'b0) noise_bad++;
      end
    end
    checks++;
    if (noise_bad != 0) begin
      errors++;
      $display("FAIL bounce_noevent: %0d clk with key_valid/key_down high, expected 0", noise_bad);
    end
    wait_frame_start();
    exp_q.push_back(4'hA);
    pressed = 16'h1000;
    wait_valid(35, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bounce_timeout: key_valid=%b after 35 clk expected 1", key_valid);
    end else begin
      exp = exp_q.pop_front();
      if (key_code !== exp) begin
        errors++;
        $display("FAIL bounce_code: got %h expected %h", key_code, exp);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [3:0] exp;
    // Dropped press while pending
    apply_reset();
    wait_frame_start();
    exp_q.push_back(4'h1);
    pressed = 16'h0001;
    wait_valid(35, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_first_timeout: key_valid=%b expected 1", key_valid);
    end else begin
      exp = exp_q.pop_front();
      if (key_code !== exp) begin errors++; $display("FAIL ovf_first_code: got %h expected %h", key_code, exp); end
    end
    pressed = '0;
    wait_down(1'b0, 64, ok);
    wait_frame_start();
    pressed = 16'h0010;
    wait_down(1'b1, 35, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_second_down: key_down=%b expected 1", key_down); end
    checks++;
    if (key_code !== 4'h1) begin errors++; $display("FAIL ovf_keep_code: got %h expected 1", key_code); end
    checks++;
    if (key_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", key_overflow); end
    checks++;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", key_valid); end

    // Ready asserted exactly on the event cycle: replacement, no overflow
    apply_reset();
    wait_frame_start();
    exp_q.push_back(4'h1);
    pressed = 16'h0001;
    wait_valid(35, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL repl_first_timeout: key_valid=%b expected 1", key_valid);
    end else begin
      exp = exp_q.pop_front();
      if (key_code !== exp) begin errors++; $display("FAIL repl_first_code: got %h expected %h", key_code, exp); end
    end
    pressed = '0;
    wait_down(1'b0, 64, ok);
    wait_frame_start();
    exp_q.push_back(4'h2);
    pressed = 16'h0010;
    wait_frame_start();
    wait_frame_start();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL repl_sb: scoreboard empty, expected one entry");
    end else begin
      exp = exp_q.pop_front();
      if (key_code !== exp) begin errors++; $display("FAIL repl_code: got %h expected %h", key_code, exp); end
    end
    checks++;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL repl_valid: got %b expected 1", key_valid); end
    checks++;
    if (key_overflow !== 1'b0) begin errors++; $display("FAIL repl_overflow: got %b expected 0", key_overflow); end
  endtask

  task automatic test_multikey();
    bit ok;
    int ev_bad;
    apply_reset();
    wait_frame_start();
    pressed = 16'h0011;
    wait_down(1'b1, 35, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_down: key_down=%b expected 1", key_down); end
    ev_bad = 0;
    repeat (64) begin
      @(negedge clk);
      if (key_valid !== 1'b0 || key_down !== 1'b1) ev_bad++;
    end
    checks++;
    if (ev_bad != 0) begin
      errors++;
      $display("FAIL multi_noevent: %0d clk with key_valid=1 or key_down=0, expected 0", ev_bad);
    end
    pressed = '0;
    wait_down(1'b0, 64, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_release: key_down=%b expected 0", key_down); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    bit ok;
    int t_prev;
    int exp_gap;
    logic [3:0] exp;
    apply_reset();
    wait_frame_start();
    repeat (4) exp_q.push_back(4'h0);
    pressed = 16'h0008;
    t_prev  = 0;
    for (int n = 0; n < 4; n++) begin
      wait_valid(60, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL repeat_timeout: event %0d missing, key_valid=%b expected 1", n, key_valid);
      end else begin
        exp = exp_q.pop_front();
        if (key_code !== exp) begin errors++; $display("FAIL repeat_code: event %0d got %h expected %h", n, key_code, exp); end
        if (n > 0) begin
          exp_gap = (n == 1) ? 48 : 32;
          checks++;
          if (cyc - t_prev != exp_gap) begin
            errors++;
            $display("FAIL repeat_gap: event %0d spacing %0d clk expected %0d", n, cyc - t_prev, exp_gap);
          end
        end
        t_prev = cyc;
      end
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
    end
    pressed = '0;
  endtask
`endif

  initial begin
    pressed       = '0;
    row_force     = 1'b0;
    row_force_val = 4'hF;
    key_ready     = 1'b0;
    rst_n         = 1'b0;
    test_reset();
    test_rotation();
    test_single_press();
    test_bounce();
    test_overflow();
    test_multikey();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
